// File: rtl/int_ctrl_pkg.sv
// Shared constants for the int_ctrl interrupt controller.
// Register select encoding and default source count.
package int_ctrl_pkg;

    localparam int NUM_SRC_DEF = 8;

    localparam logic [1:0] SEL_MASK   = 2'd0;
    localparam logic [1:0] SEL_PEND   = 2'd1;
    localparam logic [1:0] SEL_ISR    = 2'd2;
    localparam logic [1:0] SEL_SWTRIG = 2'd3;

endpackage

// File: rtl/int_ctrl_if.sv
// CPU-side bus of the interrupt controller: sources, MMIO, irq handshake.
// master = CPU/SoC side, slave = controller.
interface int_ctrl_if
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int VEC_W   = $clog2(NUM_SRC)
) ();

    logic [NUM_SRC-1:0] src;
    logic               wr_en;
    logic [1:0]         wr_sel;
    logic [NUM_SRC-1:0] wr_data;
    logic [1:0]         rd_sel;
    logic [NUM_SRC-1:0] rd_data;
    logic               irq;
    logic [VEC_W-1:0]   irq_vec;
    logic               irq_ack;
    logic               eoi;

    modport master (
        output src,
        output wr_en,
        output wr_sel,
        output wr_data,
        output rd_sel,
        output irq_ack,
        output eoi,
        input  rd_data,
        input  irq,
        input  irq_vec
    );

    modport slave (
        input  src,
        input  wr_en,
        input  wr_sel,
        input  wr_data,
        input  rd_sel,
        input  irq_ack,
        input  eoi,
        output rd_data,
        output irq,
        output irq_vec
    );

endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit plus valid.
// Index 0 is the highest priority.
module prio_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Nesting priority interrupt controller with MASK/PEND/ISR registers.
// Define INT_CTRL_EDGE_DETECT_EN for rising-edge sources (default: level).
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int VEC_W   = $clog2(NUM_SRC)
) (
    input  logic         clk,
    input  logic         rst,
    int_ctrl_if.slave    bus
);

    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] isr_q,  isr_d;
    logic               irq_q,  irq_d;
    logic [VEC_W-1:0]   vec_q,  vec_d;

    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] ack_oh;
    logic [NUM_SRC-1:0] eoi_oh;
    logic [NUM_SRC-1:0] w1c_bits;
    logic [NUM_SRC-1:0] swt_bits;
    logic [NUM_SRC-1:0] cand_vec;

    logic               wr_mask;
    logic               wr_w1c;
    logic               wr_swt;
    logic               ack_ok;
    logic               preempt;

    logic [VEC_W-1:0]   cand_idx;
    logic               cand_valid;
    logic [VEC_W-1:0]   lvl_idx;
    logic               lvl_valid;

`ifdef INT_CTRL_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] src_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0;
        end else begin
            src_q <= bus.src;
        end
    end

    assign evt = bus.src & ~src_q;
`else
    assign evt = bus.src;
`endif

    assign cand_vec = pend_q & ~mask_q;

    prio_enc #(
        .N (NUM_SRC),
        .W (VEC_W)
    ) u_cand (
        .vec_i   (cand_vec),
        .idx_o   (cand_idx),
        .valid_o (cand_valid)
    );

    prio_enc #(
        .N (NUM_SRC),
        .W (VEC_W)
    ) u_lvl (
        .vec_i   (isr_q),
        .idx_o   (lvl_idx),
        .valid_o (lvl_valid)
    );

    always_comb begin
        wr_mask = 1'b0;
        wr_w1c  = 1'b0;
        wr_swt  = 1'b0;
        if (bus.wr_en) begin
            unique case (1'b1)
                (bus.wr_sel == SEL_MASK):   wr_mask = 1'b1;
                (bus.wr_sel == SEL_PEND):   wr_w1c  = 1'b1;
                (bus.wr_sel == SEL_SWTRIG): wr_swt  = 1'b1;
                default: ;
            endcase
        end
    end

    assign w1c_bits = wr_w1c ? bus.wr_data : '0;
    assign swt_bits = wr_swt ? bus.wr_data : '0;
    assign ack_ok   = bus.irq_ack & irq_q;

    always_comb begin
        ack_oh = '0;
        eoi_oh = '0;
        if (ack_ok) begin
            ack_oh[vec_q] = 1'b1;
        end
        if (bus.eoi && lvl_valid) begin
            eoi_oh[lvl_idx] = 1'b1;
        end
    end

    // Clears first, then sets: a same-cycle event survives ack/W1C,
    // and an eoi retires the old level before the acked bit is set.
    always_comb begin
        mask_d = wr_mask ? bus.wr_data : mask_q;
        pend_d = (pend_q & ~ack_oh & ~w1c_bits) | evt | swt_bits;
        isr_d  = (isr_q & ~eoi_oh) | ack_oh;
    end

    // Only a candidate strictly above the in-service level may preempt.
    always_comb begin
        preempt = 1'b0;
        if (cand_valid) begin
            preempt = !lvl_valid || (cand_idx < lvl_idx);
        end
        irq_d = preempt && !ack_ok;
        vec_d = preempt ? cand_idx : vec_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '1;
            pend_q <= '0;
            isr_q  <= '0;
            irq_q  <= 1'b0;
            vec_q  <= '0;
        end else begin
            mask_q <= mask_d;
            pend_q <= pend_d;
            isr_q  <= isr_d;
            irq_q  <= irq_d;
            vec_q  <= vec_d;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        unique case (1'b1)
            (bus.rd_sel == SEL_MASK): bus.rd_data = mask_q;
            (bus.rd_sel == SEL_PEND): bus.rd_data = pend_q;
            (bus.rd_sel == SEL_ISR):  bus.rd_data = isr_q;
            default: ;
        endcase
    end

    assign bus.irq     = irq_q;
    assign bus.irq_vec = vec_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int_ctrl_if #(.NUM_SRC(8), .VEC_W(3)) bus ();

    int_ctrl #(.NUM_SRC(8), .VEC_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef INT_CTRL_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [7:0] m_mask, m_pend, m_isr, m_prev;
    bit         m_irq;
    int         m_vec;

    // Priority of a set: lowest set index, 8 meaning "nothing".
    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 8;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    always @(posedge clk) begin : model
        logic [7:0] ev, nisr, npend;
        int c, l;
        bit acc;
        if (rst) begin
            m_mask = 8'hFF;
            m_pend = 8'h00;
            m_isr  = 8'h00;
            m_prev = 8'h00;
            m_irq  = 1'b0;
            m_vec  = 0;
        end else begin
            ev = EDGE ? (bus.src & ~m_prev) : bus.src;
            m_prev = bus.src;
            acc = bus.irq_ack && m_irq;
            c = lowest(m_pend & ~m_mask);
            l = lowest(m_isr);
            nisr = m_isr;
            if (bus.eoi && l < 8) nisr[l] = 1'b0;
            if (acc) nisr[m_vec] = 1'b1;
            npend = m_pend;
            if (acc) npend[m_vec] = 1'b0;
            if (bus.wr_en && bus.wr_sel == SEL_PEND)
                npend = npend & ~bus.wr_data;
            npend = npend | ev;
            if (bus.wr_en && bus.wr_sel == SEL_SWTRIG)
                npend = npend | bus.wr_data;
            if (bus.wr_en && bus.wr_sel == SEL_MASK)
                m_mask = bus.wr_data;
            m_irq = !acc && (c < l);
            if (m_irq) m_vec = c;
            m_isr  = nisr;
            m_pend = npend;
        end
    end

    always @(negedge clk) begin : compare
        logic [7:0] er;
        if (chk_en) begin
            case (bus.rd_sel)
                SEL_MASK: er = m_mask;
                SEL_PEND: er = m_pend;
                SEL_ISR:  er = m_isr;
                default:  er = 8'h00;
            endcase
            chk("model irq", bus.irq, m_irq);
            if (m_irq) chk("model irq_vec", bus.irq_vec, m_vec);
            chk("model rd_data", bus.rd_data, er);
        end
    end

    task automatic cyc(input logic r, input logic [7:0] s,
                       input logic we, input logic [1:0] ws,
                       input logic [7:0] wd, input logic a,
                       input logic e);
        rst         = r;
        bus.src     = s;
        bus.wr_en   = we;
        bus.wr_sel  = ws;
        bus.wr_data = wd;
        bus.irq_ack = a;
        bus.eoi     = e;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.src     = '0;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = '0;
        bus.wr_data = '0;
        bus.irq_ack = 1'b0;
        bus.eoi     = 1'b0;
    endtask

    task automatic idle();
        cyc(0, 8'h00, 0, 2'd0, 8'h00, 0, 0);
    endtask

    task automatic wr(input logic [1:0] ws, input logic [7:0] wd);
        cyc(0, 8'h00, 1, ws, wd, 0, 0);
    endtask

    task automatic rd(input logic [1:0] sel, input logic [7:0] exp,
                      input string nm);
        bus.rd_sel = sel;
        #1;
        chk(nm, bus.rd_data, exp);
    endtask

    initial begin
        rst         = 1'b1;
        bus.src     = '0;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = '0;
        bus.wr_data = '0;
        bus.rd_sel  = '0;
        bus.irq_ack = 1'b0;
        bus.eoi     = 1'b0;

        cyc(1, 8'h00, 0, 2'd0, 8'h00, 0, 0);
        chk_en = 1'b1;
        rd(SEL_MASK, 8'hFF, "reset MASK");
        rd(SEL_PEND, 8'h00, "reset PEND");
        rd(SEL_ISR,  8'h00, "reset ISR");
        chk("reset irq", bus.irq, 0);

        // Single source, one-cycle PEND latency then irq.
        wr(SEL_MASK, 8'h00);
        cyc(0, 8'h20, 0, 2'd0, 8'h00, 0, 0);
        rd(SEL_PEND, 8'h20, "s5 PEND");
        chk("s5 irq early", bus.irq, 0);
        idle();
        chk("s5 irq", bus.irq, 1);
        chk("s5 vec", bus.irq_vec, 5);
        cyc(0, 8'h00, 0, 2'd0, 8'h00, 1, 0);
        chk("s5 irq after ack", bus.irq, 0);
        rd(SEL_ISR, 8'h20, "s5 ISR");
        cyc(0, 8'h00, 0, 2'd0, 8'h00, 0, 1);
        rd(SEL_ISR, 8'h00, "s5 ISR eoi");

        // Two simultaneous sources: priority then lower one after eoi.
        cyc(0, 8'h44, 0, 2'd0, 8'h00, 0, 0);
        idle();
        chk("s26 vec", bus.irq_vec, 2);
        cyc(0, 8'h00, 0, 2'd0, 8'h00, 1, 0);
        idle();
        rd(SEL_ISR, 8'h04, "s26 ISR");
        chk("s26 irq held", bus.irq, 0);
        cyc(0, 8'h00, 0, 2'd0, 8'h00, 0, 1);
        idle();
        chk("s26 irq 6", bus.irq, 1);
        chk("s26 vec 6", bus.irq_vec, 6);
        cyc(0, 8'h00, 0, 2'd0, 8'h00, 1, 0);

        // Nesting over ISR=0x40.
        cyc(0, 8'h02, 0, 2'd0, 8'h00, 0, 0);
        idle();
        chk("nest irq", bus.irq, 1);
        chk("nest vec", bus.irq_vec, 1);
        cyc(0, 8'h00, 0, 2'd0, 8'h00, 1, 0);
        rd(SEL_ISR, 8'h42, "nest ISR ack");
        cyc(0, 8'h00, 0, 2'd0, 8'h00, 0, 1);
        rd(SEL_ISR, 8'h40, "nest ISR eoi");
        cyc(0, 8'h00, 0, 2'd0, 8'h00, 0, 1);

        // SWTRIG under mask, unmask, then W1C before ack.
        wr(SEL_MASK, 8'hFF);
        wr(SEL_SWTRIG, 8'h08);
        idle();
        rd(SEL_PEND, 8'h08, "swt PEND");
        chk("swt masked irq", bus.irq, 0);
        wr(SEL_MASK, 8'hF7);
        idle();
        chk("swt irq", bus.irq, 1);
        chk("swt vec", bus.irq_vec, 3);
        wr(SEL_PEND, 8'h08);
        idle();
        chk("w1c irq", bus.irq, 0);

        // Event with its own ack, then reset mid-service.
        wr(SEL_MASK, 8'h00);
        cyc(0, 8'h10, 0, 2'd0, 8'h00, 0, 0);
        idle();
        chk("s4 vec", bus.irq_vec, 4);
        cyc(0, 8'h10, 0, 2'd0, 8'h00, 1, 0);
        rd(SEL_PEND, 8'h10, "s4 PEND set wins");
        cyc(1, 8'hFF, 1, SEL_SWTRIG, 8'hFF, 0, 1);
        rd(SEL_MASK, 8'hFF, "rst MASK");
        rd(SEL_PEND, 8'h00, "rst PEND");
        rd(SEL_ISR,  8'h00, "rst ISR");
        chk("rst irq", bus.irq, 0);

        // src[0] held high for five cycles, acked once.
        wr(SEL_MASK, 8'h00);
        cyc(0, 8'h01, 0, 2'd0, 8'h00, 0, 0);
        cyc(0, 8'h01, 0, 2'd0, 8'h00, 0, 0);
        chk("hold irq", bus.irq, 1);
        cyc(0, 8'h01, 0, 2'd0, 8'h00, 1, 0);
        rd(SEL_PEND, EDGE ? 8'h00 : 8'h01, "hold PEND after ack");
        cyc(0, 8'h01, 0, 2'd0, 8'h00, 0, 0);
        cyc(0, 8'h01, 0, 2'd0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 2'd0, 8'h00, 0, 1);

        // Randomized traffic, checked by the compare process.
        cyc(1, 8'h00, 0, 2'd0, 8'h00, 0, 0);
        wr(SEL_MASK, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] s;
            s = '0;
            for (int b = 0; b < 8; b++) begin
                s[b] = ($urandom_range(0, 11) == 0);
            end
            bus.rd_sel = 2'($urandom_range(0, 3));
            cyc(($urandom_range(0, 249) == 0), s,
                ($urandom_range(0, 6) == 0),
                2'($urandom_range(0, 3)),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
